fetch_cycle: RTL and testbench
==============================

# fetch_cycle

Instruction-fetch stage feeding the decode stage. Holds the architectural fetch PC and issues in-order requests to instruction memory through a valid/ready handshake. Buffers returned instructions with their PCs in a small queue and presents one instruction per cycle to the decode pipeline register. Honours decode stalls, and squashes wrong-path fetches when decode redirects the PC on a jump or branch.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- QUEUE_DEPTH, 4, fetch-queue entries and maximum in-flight requests (power of 2, ≥2)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  request address, word aligned
- imem_rsp_valid  in  1  response valid; responses are in order, one per accepted request, at least 1 cycle after acceptance
- imem_rsp_data  in  XLEN  fetched instruction word
- f_to_d_enable_ff  in  1  decode-stage enable from hazard mitigation; 0 = hold outputs
- redirect_valid  in  1  decode resolved a jump/branch to a non-sequential PC
- redirect_pc  in  XLEN  redirect target
- instr_valid  out  1  instruction/PC_out carry a real instruction
- instruction  out  XLEN  to decode `instruction`
- PC_out  out  XLEN  to decode `PC_in`

## Operation
- The state machine has two states, RUN and DRAIN. Reset enters RUN.
- **RUN**
  - Assert imem_req_valid when credits (queue count + outstanding) < QUEUE_DEPTH.
  - On a request handshake (valid & ready): the fetch PC advances by 4, wrapping modulo 2^XLEN, and outstanding increments.
- **Response handling:** on imem_rsp_valid, outstanding decrements.
  - In RUN, push {in-flight PC, imem_rsp_data} into the queue. In-flight PCs are tracked in an internal QUEUE_DEPTH PC FIFO.
  - In DRAIN, discard the response.
- **Output register:** loads when f_to_d_enable_ff = 1.
  - Queue non-empty: pop the head; instr_valid = 1.
  - Queue empty: load NOP 32'h0000_0013 and the current fetch PC; instr_valid = 0.
  - f_to_d_enable_ff = 0: the output register, and therefore the queue head, holds.
- **redirect_valid**, which overrides everything in the same cycle:
  - Fetch PC ← {redirect_pc[XLEN-1:2], 2'b00}; queue and PC FIFO flushed.
  - Output register ← NOP with instr_valid = 0, even if f_to_d_enable_ff = 0.
  - A response arriving that cycle is discarded.
  - No request is issued that cycle.
  - Next state is DRAIN if outstanding (after this cycle's decrement) > 0, else RUN.
- **DRAIN:** imem_req_valid = 0; responses are discarded; go to RUN when outstanding reaches 0.
  - A redirect in DRAIN reloads the fetch PC and stays in DRAIN.
- **Request stability:** imem_req_addr and imem_req_valid stay stable while valid & !ready, except when a redirect withdraws the request (memory treats this as legal).

## Timing
- **Reset values (rst low):**
  - imem_req_valid 0, imem_req_addr RESET_PC
  - instr_valid 0, instruction 32'h0000_0013, PC_out RESET_PC
  - queue empty, outstanding 0, state RUN
- **After reset release:** imem_req_valid = 1 on the first clock edge after rst rises, with address RESET_PC.
- **Latency:** a response at edge N with the queue empty and enable = 1 appears on instruction at edge N+1. Queue bypass is not permitted; the path goes through the queue/output register.
- **Throughput:** one instruction per cycle with a 1-cycle memory and no stalls.
- **Queue full:** credits = QUEUE_DEPTH → no request. Credits are released on the same edge an entry pops, so a request may be issued in that cycle.
- **Simultaneous events:** request accept, response, and pop in the same cycle must all take effect; the counters use the net change.

## Structure
- Shared package `fetch_pkg`:
  - `NOP_INSTR` = 32'h0000_0013
  - `fetch_state_t` enum {RUN, DRAIN}
  - struct `fetch_entry_t` {pc, instr}
  - opcode constants JAL / JALR / BRANCH, shared with decode
- Sub-module `fetch_queue`: synchronous FIFO parameterised on depth and entry type, with push/pop/flush/count and async active-low reset. It is instantiated twice, once for entries and once for in-flight PCs.

## Test plan
- **Reset + streaming:** reset, 1-cycle memory returning addr+0x100 as data → requests 0x0, 0x4, 0x8…; PC_out 0x0 with instruction 0x100 one cycle after the first response; then one instruction per cycle.
- **Backpressure:** imem_req_ready low for 5 cycles at addr 0x8 → imem_req_addr stays 0x8 and valid stays 1; no duplicate or skipped PCs afterwards.
- **Decode stall:** f_to_d_enable_ff = 0 for 3 cycles → instruction/PC_out held; queue fills to 4 and imem_req_valid drops; after release, PCs resume in order with none lost.
- **Redirect with 3 outstanding, 4-cycle memory:** redirect_pc 0x40 → NOP with instr_valid 0 next cycle; 3 responses discarded in DRAIN; the first new request is 0x40 only after outstanding reaches 0; next valid PC_out is 0x40.
- **Edge cases:** redirect_pc 0x43 → fetch at 0x40. Fetch PC 0xFFFF_FFFC advances to 0x0. Redirect coincident with a response → that response is not delivered.
- **Mid-operation reset:** assert rst with the queue and requests in flight → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch/decode types and constants
package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Control-flow opcodes decode uses to raise a redirect
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO with flush, generic entry type
module fetch_queue #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_cycle.sv
// rtl/fetch_cycle.sv - instruction fetch stage with queue, stall and redirect
module fetch_cycle
  import fetch_pkg::*;
#(
  parameter int              XLEN        = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            f_to_d_enable_ff,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] PC_out
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] redirect_aligned;
  logic [XLEN-1:0] inflight_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   ent_count;
  logic [CW-1:0]   pcq_count;
  logic [CW-1:0]   credits;
  logic            req_en;
  logic            req_fire;
  logic            push_ent;
  logic            pop_ent;
  fetch_entry_t    ent_in;
  fetch_entry_t    ent_head;
  logic            unused_pcq;

  assign req_fire         = imem_req_valid && imem_req_ready;
  assign credits          = ent_count + outstanding;
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  assign redirect_aligned = redirect_pc & ~XLEN'(3);
  assign imem_req_addr    = fetch_pc;
  assign ent_in           = '{pc: inflight_pc, instr: imem_rsp_data};
  assign unused_pcq       = ^pcq_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    push_ent       = 1'b0;
    unique case (state)
      RUN: begin
        imem_req_valid = req_en && !redirect_valid && (credits < CW'(QUEUE_DEPTH));
        push_ent       = imem_rsp_valid && !redirect_valid;
      end
      DRAIN: begin
        if (outstanding_next == '0) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
    // Wrong-path responses still owed by memory must be drained first
    if (redirect_valid) state_next = (outstanding_next != '0) ? DRAIN : RUN;
    pop_ent = f_to_d_enable_ff && !redirect_valid && (ent_count != '0);
  end

  // req_en keeps the request low until the first edge after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_en      <= 1'b0;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
    end else begin
      req_en      <= 1'b1;
      outstanding <= outstanding_next;
      if (redirect_valid)  fetch_pc <= redirect_aligned;
      else if (req_fire)   fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      PC_out      <= RESET_PC;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      PC_out      <= redirect_aligned;
    end else if (f_to_d_enable_ff) begin
      if (pop_ent) begin
        instr_valid <= 1'b1;
        instruction <= ent_head.instr;
        PC_out      <= ent_head.pc;
      end else begin
        instr_valid <= 1'b0;
        instruction <= NOP_INSTR;
        PC_out      <= fetch_pc;
      end
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH), .T(fetch_entry_t)) u_entry_q (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push_ent),
    .push_data (ent_in),
    .pop       (pop_ent),
    .flush     (redirect_valid),
    .head      (ent_head),
    .count     (ent_count)
  );

  fetch_queue #(.DEPTH(QUEUE_DEPTH), .T(logic [XLEN-1:0])) u_pc_q (
    .clk       (clk),
    .rst_n     (rst),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (push_ent),
    .flush     (redirect_valid),
    .head      (inflight_pc),
    .count     (pcq_count)
  );

endmodule

// File: tb/tb_fetch_cycle.sv
// tb/tb_fetch_cycle.sv - self-checking bench for fetch_cycle
module tb_fetch_cycle;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        f_to_d_enable_ff;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;

  fetch_cycle #(.XLEN(32), .RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst_n),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .f_to_d_enable_ff (f_to_d_enable_ff),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instruction      (instruction),
    .PC_out           (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  mreq_t       mem_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          avail = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] exp_req = RST_PC;
  bit          started = 1'b0;
  bit          draining = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One clock: memory + program-order model of what decode must see
  task automatic step();
    mreq_t       r;
    bit          rsp, redir, en, hs, exp_rv, prev_iv;
    logic [31:0] tgt, hs_addr, prev_instr, prev_pc;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_data(mem_q[0].addr) : $urandom;
    @(negedge clk);
    redir   = redirect_valid;
    en      = f_to_d_enable_ff;
    tgt     = redirect_pc & 32'hFFFF_FFFC;
    exp_rv  = started && !draining && !redir && ((avail + mem_q.size()) < DEPTH);
    check_bit("req_valid", imem_req_valid, exp_rv);
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_req);
    hs         = imem_req_valid && imem_req_ready;
    hs_addr    = imem_req_addr;
    prev_iv    = instr_valid;
    prev_instr = instruction;
    prev_pc    = pc_out;
    @(posedge clk);
    #1;
    if (redir) begin
      check_bit("redir_iv", instr_valid, 1'b0);
      check("redir_instr", instruction, NOP_INSTR);
    end else if (en) begin
      if (avail > 0) begin
        check_bit("out_valid", instr_valid, 1'b1);
        check("out_pc", pc_out, exp_pc);
        check("out_instr", instruction, mem_data(exp_pc));
        exp_pc += 32'd4;
        avail--;
      end else begin
        check_bit("bubble_iv", instr_valid, 1'b0);
        check("bubble_instr", instruction, NOP_INSTR);
      end
    end else begin
      check_bit("hold_iv", instr_valid, prev_iv);
      check("hold_instr", instruction, prev_instr);
      check("hold_pc", pc_out, prev_pc);
    end
    if (rsp) begin
      r = mem_q.pop_front();
      if (!redir && r.epoch == epoch) avail++;
    end
    if (hs) begin
      r.addr  = hs_addr;
      r.due   = cyc + $urandom_range(lat_max, lat_min);
      r.epoch = epoch;
      mem_q.push_back(r);
      exp_req += 32'd4;
    end
    if (redir) begin
      epoch++;
      avail    = 0;
      exp_req  = tgt;
      exp_pc   = tgt;
      draining = (mem_q.size() > 0);
    end else if (draining && mem_q.size() == 0) begin
      draining = 1'b0;
    end
    started = 1'b1;
    cyc++;
  endtask

  task automatic redirect_step(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    check_bit("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check_bit("rst_iv", instr_valid, 1'b0);
    check("rst_instr", instruction, NOP_INSTR);
    check("rst_pc", pc_out, RST_PC);
    mem_q.delete();
    avail          = 0;
    epoch++;
    draining       = 1'b0;
    started        = 1'b0;
    exp_pc         = RST_PC;
    exp_req        = RST_PC;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic drain_wait(input string tag);
    int n;
    n = 0;
    while (draining && n < 30) begin
      step();
      n++;
    end
    check_bit(tag, draining, 1'b0);
  endtask

  task automatic wait_valid_out(input string tag, input logic [31:0] want_pc);
    int n;
    n = 0;
    while (!instr_valid && n < 30) begin
      step();
      n++;
    end
    check_bit({tag, "_seen"}, instr_valid, 1'b1);
    check({tag, "_pc"}, pc_out, want_pc);
  endtask

  initial begin
    int          n;
    logic [31:0] tgt;
    imem_req_ready   = 1'b1;
    imem_rsp_valid   = 1'b0;
    imem_rsp_data    = '0;
    f_to_d_enable_ff = 1'b1;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;

    apply_reset();

    // Streaming from reset, then backpressure while address 0x8 is offered
    repeat (3) step();
    check("stream_addr8", imem_req_addr, 32'h8);
    imem_req_ready = 1'b0;
    step();
    check_bit("lat_iv", instr_valid, 1'b1);
    check("lat_pc", pc_out, 32'h0);
    check("lat_instr", instruction, 32'h100);
    check_bit("bp_valid", imem_req_valid, 1'b1);
    check("bp_addr", imem_req_addr, 32'h8);
    repeat (4) begin
      step();
      check_bit("bp_valid", imem_req_valid, 1'b1);
      check("bp_addr", imem_req_addr, 32'h8);
    end
    imem_req_ready = 1'b1;
    repeat (6) step();
    for (int i = 0; i < 6; i++) begin
      step();
      check_bit("tput_iv", instr_valid, 1'b1);
    end

    // Decode stall fills the queue and throttles requests
    f_to_d_enable_ff = 1'b0;
    repeat (8) step();
    check_bit("stall_req_drop", imem_req_valid, 1'b0);
    f_to_d_enable_ff = 1'b1;
    repeat (12) step();

    // Redirect with several responses in flight on a 4-cycle memory
    lat_min = 4;
    lat_max = 4;
    n = 0;
    while (mem_q.size() < 3 && n < 40) begin
      step();
      n++;
    end
    check_bit("inflight_setup", (mem_q.size() >= 3), 1'b1);
    redirect_step(32'h40);
    check_bit("redir40_iv", instr_valid, 1'b0);
    drain_wait("drain40_done");
    check_bit("redir40_req_valid", imem_req_valid, 1'b1);
    check("redir40_req_addr", imem_req_addr, 32'h40);
    wait_valid_out("redir40_out", 32'h40);

    // Unaligned redirect target
    lat_min = 1;
    lat_max = 1;
    redirect_step(32'h43);
    drain_wait("drain43_done");
    check_bit("redir43_req_valid", imem_req_valid, 1'b1);
    check("redir43_req_addr", imem_req_addr, 32'h40);
    wait_valid_out("redir43_out", 32'h40);

    // PC wrap at the top of the address space
    redirect_step(32'hFFFF_FFF6);
    n = 0;
    while (!(instr_valid && pc_out == 32'h0) && n < 40) begin
      step();
      n++;
    end
    check("wrap_pc", pc_out, 32'h0);
    check("wrap_instr", instruction, 32'h100);

    // Redirect in the same cycle a response arrives
    n = 0;
    while (!(mem_q.size() > 0 && mem_q[0].due <= cyc) && n < 20) begin
      step();
      n++;
    end
    check_bit("coinc_setup", (mem_q.size() > 0 && mem_q[0].due <= cyc), 1'b1);
    redirect_step(32'h200);
    check_bit("coinc_iv", instr_valid, 1'b0);
    wait_valid_out("coinc_out", 32'h200);

    // Randomized traffic
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready   = ($urandom_range(3) != 0);
      f_to_d_enable_ff = ($urandom_range(4) != 0);
      if ($urandom_range(31) == 0) begin
        tgt = ($urandom_range(1) == 1) ? 32'($urandom) : (32'hFFFF_FFF0 | 32'($urandom_range(15)));
        redirect_step(tgt);
      end else begin
        step();
      end
    end

    // Reset in the middle of traffic
    imem_req_ready   = 1'b1;
    f_to_d_enable_ff = 1'b0;
    lat_min = 3;
    lat_max = 3;
    repeat (3) step();
    apply_reset();
    f_to_d_enable_ff = 1'b1;
    lat_min = 1;
    lat_max = 1;
    wait_valid_out("post_reset_out", RST_PC);
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
